// File: rtl/stage_pipe_pkg.sv
// Shared types and legal ranges for the elastic pipe segment.
package stage_pipe_pkg;

    localparam int DEPTH_MIN      = 1;
    localparam int DEPTH_MAX      = 8;
    localparam int CTRL_DEPTH_MIN = 0;
    localparam int CTRL_DEPTH_MAX = 8;

    localparam int CTRL_TDATA_W = 512;
    localparam int CTRL_TUSER_W = 128;
    localparam int CTRL_TKEEP_W = CTRL_TDATA_W / 8;

    typedef struct packed {
        logic [CTRL_TDATA_W-1:0] tdata;
        logic [CTRL_TUSER_W-1:0] tuser;
        logic [CTRL_TKEEP_W-1:0] tkeep;
        logic                    tvalid;
        logic                    tlast;
    } ctrl_beat_t;

endpackage

// File: rtl/skid_slice.sv
// One registered valid/ready slice: main register plus skid register, so
// ready toward upstream comes from a flop instead of from downstream ready.
module skid_slice #(
    parameter int DATA_W = 1124
) (
    input  logic              axis_clk,
    input  logic              aresetn,
    input  logic              clr,
    input  logic              in_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              inc,
    output logic              dec
);

    logic              main_vld;
    logic              skid_vld;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              acc;
    logic              drain;

    assign in_ready  = in_en & ~skid_vld & ~clr;
    assign acc       = in_valid & in_ready;
    assign drain     = main_vld & out_ready;
    assign out_valid = main_vld;
    assign out_data  = main_data;
    assign inc       = acc;
    assign dec       = drain;

    always_ff @(posedge axis_clk) begin
        if (!aresetn || clr) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || drain) begin
            // skid full implies in_ready=0, so acc and skid_vld never coincide
            main_vld <= skid_vld | acc;
            skid_vld <= 1'b0;
        end else if (acc) begin
            skid_vld <= 1'b1;
        end
    end

    // Data holds its value whenever main is valid and stalled.
    always_ff @(posedge axis_clk) begin
        if (!main_vld || drain)
            main_data <= skid_vld ? skid_data : in_data;
        if (main_vld && !drain && acc)
            skid_data <= in_data;
    end

endmodule

// File: rtl/stage_elastic_pipe.sv
// Elastic data pipe of DEPTH skid slices plus a fixed-delay control AXIS line.
// Optional flush input when STAGE_ELASTIC_PIPE_FLUSH_EN is defined.
module stage_elastic_pipe
    import stage_pipe_pkg::*;
#(
    parameter int DATA_W               = 1124,
    parameter int DEPTH                = 2,
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int CTRL_DEPTH           = 2,
    parameter int OCC_W                = $clog2(2*DEPTH+1)
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
`ifdef STAGE_ELASTIC_PIPE_FLUSH_EN
    input  logic                              flush,
`endif
    input  logic [DATA_W-1:0]                 s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [DATA_W-1:0]                 m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    output logic [OCC_W-1:0]                  occupancy
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("stage_elastic_pipe: DEPTH out of range");
    end
    if (CTRL_DEPTH < CTRL_DEPTH_MIN || CTRL_DEPTH > CTRL_DEPTH_MAX) begin : g_bad_ctrl_depth
        $error("stage_elastic_pipe: CTRL_DEPTH out of range");
    end
    if (C_S_AXIS_DATA_WIDTH > CTRL_TDATA_W || C_S_AXIS_TUSER_WIDTH > CTRL_TUSER_W) begin : g_bad_ctrl_w
        $error("stage_elastic_pipe: control widths exceed ctrl_beat_t");
    end

    logic clr;
`ifdef STAGE_ELASTIC_PIPE_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    // Holds s_ready low through reset and releases it one cycle after.
    logic rdy_en;
    always_ff @(posedge axis_clk) begin
        if (!aresetn) rdy_en <= 1'b0;
        else          rdy_en <= 1'b1;
    end

    logic [DEPTH:0]    vld;
    logic [DEPTH:0]    rdy;
    logic [DATA_W-1:0] dat [DEPTH+1];
    logic [DEPTH-1:0]  inc_v;
    logic [DEPTH-1:0]  dec_v;

    assign vld[0]     = s_valid;
    assign dat[0]     = s_data;
    assign rdy[DEPTH] = m_ready;
    assign s_ready    = rdy[0];
    assign m_valid    = vld[DEPTH];
    assign m_data     = vld[DEPTH] ? dat[DEPTH] : '0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        skid_slice #(.DATA_W(DATA_W)) u_slice (
            .axis_clk  (axis_clk),
            .aresetn   (aresetn),
            .clr       (clr),
            .in_en     ((k == 0) ? rdy_en : 1'b1),
            .in_data   (dat[k]),
            .in_valid  (vld[k]),
            .in_ready  (rdy[k]),
            .out_data  (dat[k+1]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .inc       (inc_v[k]),
            .dec       (dec_v[k])
        );
    end

    // Interior hand-offs add to both sums and cancel; the net is in - out.
    logic [OCC_W-1:0] n_inc;
    logic [OCC_W-1:0] n_dec;
    always_comb begin
        n_inc = '0;
        n_dec = '0;
        for (int k = 0; k < DEPTH; k++) begin
            n_inc = n_inc + OCC_W'(inc_v[k]);
            n_dec = n_dec + OCC_W'(dec_v[k]);
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn || clr) occupancy <= '0;
        else                 occupancy <= occupancy + n_inc - n_dec;
    end

    ctrl_beat_t ctrl_in;
    ctrl_beat_t ctrl_out;

    assign ctrl_in = '{tdata:  CTRL_TDATA_W'(c_s_axis_tdata),
                       tuser:  CTRL_TUSER_W'(c_s_axis_tuser),
                       tkeep:  CTRL_TKEEP_W'(c_s_axis_tkeep),
                       tvalid: c_s_axis_tvalid,
                       tlast:  c_s_axis_tlast};

    // Control beats shift every cycle regardless of data-path stalls.
    if (CTRL_DEPTH == 0) begin : g_ctrl_pass
        assign ctrl_out = ctrl_in;
    end else begin : g_ctrl_pipe
        ctrl_beat_t ctrl_p [CTRL_DEPTH];
        always_ff @(posedge axis_clk) begin
            if (!aresetn) begin
                for (int i = 0; i < CTRL_DEPTH; i++) ctrl_p[i] <= '0;
            end else begin
                ctrl_p[0] <= ctrl_in;
                for (int i = 1; i < CTRL_DEPTH; i++) ctrl_p[i] <= ctrl_p[i-1];
            end
        end
        assign ctrl_out = ctrl_p[CTRL_DEPTH-1];
    end

    assign c_m_axis_tdata  = ctrl_out.tdata[C_S_AXIS_DATA_WIDTH-1:0];
    assign c_m_axis_tuser  = ctrl_out.tuser[C_S_AXIS_TUSER_WIDTH-1:0];
    assign c_m_axis_tkeep  = ctrl_out.tkeep[C_S_AXIS_DATA_WIDTH/8-1:0];
    assign c_m_axis_tvalid = ctrl_out.tvalid;
    assign c_m_axis_tlast  = ctrl_out.tlast;

endmodule

// File: doc/stage_elastic_pipe.md
Name: stage_elastic_pipe

Overview:
- Parametrised elastic pipeline segment for inter-module links inside a match-action stage (key extract -> lookup -> action).
- Successor to the plain free-running boundary registers: it honours valid/ready backpressure through DEPTH skid slices without losing throughput.
- Also carries the control-path AXIS bus through a matched CTRL_DEPTH delay line.
- Reports live data occupancy.

Parameters:
- DATA_W, 1124: width of the data bundle (PHV plus any side fields, e.g. vlan).
- DEPTH, 2: number of skid slices, 1..8.
- C_S_AXIS_DATA_WIDTH, 512: control tdata width.
- C_S_AXIS_TUSER_WIDTH, 128: control tuser width.
- CTRL_DEPTH, 2: control-path register stages, 0..8. 0 = combinational pass-through.
- OCC_W, $clog2(2*DEPTH+1): occupancy counter width.

Ports:
- axis_clk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_data  in  DATA_W  upstream data
- s_valid  in  1  upstream valid
- s_ready  out  1  ready to upstream
- m_data  out  DATA_W  downstream data
- m_valid  out  1  downstream valid
- m_ready  in  1  downstream ready
- c_s_axis_tdata/tuser/tkeep/tvalid/tlast  in  C_S_AXIS_DATA_WIDTH/C_S_AXIS_TUSER_WIDTH/C_S_AXIS_DATA_WIDTH/8/1/1  control in
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  same widths  control out
- occupancy  out  OCC_W  words currently held in the data pipe

Behaviour:
- Reset is aresetn, synchronous, active-low, on axis_clk.
- Reset clears all slice valids, skid valids, control stage regs (all fields 0) and occupancy.
- Output values during reset: s_ready=0, m_valid=0, m_data=0, c_m_axis_* all 0, occupancy=0.
- s_ready rises the first cycle after reset release.
- Slice k (0..DEPTH-1) holds a main register and a skid register. Slice 0 is fed by s_*; slice DEPTH-1 drives m_*.
- in_ready(k) = ~skid_valid(k), taken from a register, never combinational from downstream ready. s_ready = in_ready(0).
- Slice transfer happens when valid and ready are both high on the same edge.
- Main empty, or main draining this cycle: the accepted word enters main.
- Main full and stalled: the accepted word enters skid.
- When main drains and skid is full, skid moves to main and skid clears.
- Order is strictly FIFO. No word is dropped or duplicated.
- Latency with m_ready held high is DEPTH cycles from s_valid&s_ready to m_valid. Throughput is 1 word/cycle.
- Full backpressure (m_ready=0) holds 2*DEPTH words. s_ready falls the cycle after the last slot fills.
- Buffered data does not change while a slice is stalled (AXIS stability).
- occupancy is registered:
  - +1 on an upstream accept, -1 on a downstream accept.
  - Unchanged when both happen together.
  - Never exceeds 2*DEPTH.
- Control path:
  - Unconditional shift every cycle. No backpressure. Control traffic is unaffected by data stalls.
  - All five fields are delayed together by exactly CTRL_DEPTH cycles.
- Reset mid-stream discards every held data word and control beat. Nothing is emitted after release until new input arrives.

Optional Feature:
- Macro: STAGE_ELASTIC_PIPE_FLUSH_EN.
- Enabled: adds input flush (1 bit).
  - flush=1 clears all data valids and occupancy on the next edge; data registers are don't-care.
  - s_ready is forced to 0 during the flush cycle.
  - An upstream word offered in the flush cycle is not accepted.
  - The control path is untouched.
  - flush has priority over simultaneous accept and drain.
- Disabled: no flush port, and the logic is absent.

Decomposition:
- Package stage_pipe_pkg holds the control-beat struct (tdata, tuser, tkeep, tvalid, tlast) and the DEPTH/CTRL_DEPTH legal-range constants.
- One sub-module, skid_slice (DATA_W parameter, valid/ready in and out, occupancy inc/dec strobes), instantiated DEPTH times in a generate loop.
- The control delay line stays inline.

Test Plan:
- Streaming: DEPTH=2, m_ready=1, send 0x1..0x10 back-to-back. m_data shows 0x1..0x10 in order, first word 2 cycles after the first accept, no gaps, occupancy ≤2.
- Full stall: m_ready=0, drive s_valid=1 with 0xA0..0xA5. Exactly 4 accepted and s_ready=0 after the 4th. Release m_ready and get 0xA0..0xA3, then 0xA4, 0xA5, with no loss.
- Random valid/ready: 50% toggling on both sides, 10k words, scoreboard FIFO compare. Zero mismatches, and m_data stable while m_valid&~m_ready.
- Control delay: CTRL_DEPTH=2, beat tdata=0xDEAD with tlast=1 while data is stalled. It appears on c_m_axis exactly 2 cycles later with tlast=1.
- Reset mid-stream: occupancy=3, assert aresetn=0 for 1 cycle. m_valid=0 and occupancy=0, and no stale word appears after release.
- Flush (STAGE_ELASTIC_PIPE_FLUSH_EN): with occupancy=4, pulse flush together with s_valid=1 data 0x55. Next cycle occupancy=0 and m_valid=0, and 0x55 never appears.
